// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types and helpers for the serial adder slice.
//   state_t    - FSM state encoding {IDLE, RUN, DONE}
//   cnt_width  - step-counter width, clog2(nstep) with a floor of 1
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter width for an nstep-long run; a single-step run still needs one bit.
  function automatic int unsigned cnt_width(input int unsigned nstep);
    int unsigned w;
    w = 32'($clog2(nstep));
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if: start/done request bus of the serial adder.
//   master drives start, sub, a, b, ci and observes busy, done, s, co (ovf).
//   slave  (the adder) is the mirror image.
// The ovf signal exists only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             co;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;

  modport master (output start, sub, a, b, ci, input busy, done, s, co, ovf);
  modport slave  (input start, sub, a, b, ci, output busy, done, s, co, ovf);
`else
  modport master (output start, sub, a, b, ci, input busy, done, s, co);
  modport slave  (input start, sub, a, b, ci, output busy, done, s, co);
`endif
endinterface

// File: rtl/serial_adder_digit_adder.sv
// digit_adder: combinational DIGIT-bit ripple of full-adder cells.
//   a, b      DIGIT-bit operand slices
//   ci        carry into bit 0
//   s         DIGIT-bit sum
//   co        carry out of the MSB
//   c_msb_in  carry into the MSB (signed-overflow detection)
module digit_adder #(
  parameter int unsigned DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  // Full-adder ripple; c[i] is the carry into bit i.
  always_comb begin
    logic [DIGIT:0] c;
    c        = '0;
    s        = '0;
    c[0]     = ci;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    co       = c[DIGIT];
    c_msb_in = c[DIGIT-1];
  end

endmodule

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle WIDTH-bit adder/subtractor, DIGIT bits per clock.
//   clk, rst_n  clock and asynchronous active-low reset
//   bus         serial_adder_if slave: start/sub/a/b/ci in, busy/done/s/co out
// Subtraction is a + ~b + ~ci, so co reads as NOT borrow.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow flag bus.ovf.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input logic           clk,
  input logic           rst_n,
  serial_adder_if.slave bus
);

  localparam int unsigned NSTEP = WIDTH / DIGIT;
  localparam int unsigned CW    = cnt_width(NSTEP);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] acc;

  logic [DIGIT-1:0] sl_s_c;
  logic             sl_co_c;
  logic             sl_cm_c;
  logic [WIDTH-1:0] acc_nxt_c;

  // One digit slice per cycle, fed from the low end of the shifting operands.
  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a        (opa[DIGIT-1:0]),
    .b        (opb[DIGIT-1:0]),
    .ci       (carry),
    .s        (sl_s_c),
    .co       (sl_co_c),
    .c_msb_in (sl_cm_c)
  );

  // New sum bits enter at the top; after NSTEP steps slice 0 sits at bit 0.
  assign acc_nxt_c = WIDTH'({sl_s_c, acc} >> DIGIT);

`ifndef SERIAL_ADDER_OVF_EN
  logic unused_cm;
  assign unused_cm = sl_cm_c;
`endif

  // FSM and datapath; every output is a register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      carry    <= 1'b0;
      opa      <= '0;
      opb      <= '0;
      acc      <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.s    <= '0;
      bus.co   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      bus.ovf  <= 1'b0;
`endif
    end else begin
      bus.done <= 1'b0;
      case (state)
        RUN: begin
          opa   <= opa >> DIGIT;
          opb   <= opb >> DIGIT;
          acc   <= acc_nxt_c;
          carry <= sl_co_c;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(NSTEP - 1)) begin
            state    <= DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            bus.s    <= acc_nxt_c;
            bus.co   <= sl_co_c;
`ifdef SERIAL_ADDER_OVF_EN
            bus.ovf  <= sl_cm_c ^ sl_co_c;
`endif
          end
        end
        default: begin
          // IDLE and DONE both accept a request; start during RUN is ignored.
          cnt <= '0;
          if (bus.start) begin
            state    <= RUN;
            bus.busy <= 1'b1;
            opa      <= bus.a;
            opb      <= bus.sub ? ~bus.b : bus.b;
            carry    <= bus.ci ^ bus.sub;
          end else begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed self-checking bench for serial_adder.
// Three instances: WIDTH=1/DIGIT=1, WIDTH=8/DIGIT=1, WIDTH=8/DIGIT=2.
// Define SERIAL_ADDER_OVF_EN to also check the ovf flag.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  logic unused_ovf_exp;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(1)) if1  ();
  serial_adder_if #(.WIDTH(8)) if8  ();
  serial_adder_if #(.WIDTH(8)) if82 ();

  serial_adder #(.WIDTH(1), .DIGIT(1)) u_w1  (.clk(clk), .rst_n(rst_n), .bus(if1));
  serial_adder #(.WIDTH(8), .DIGIT(1)) u_w8  (.clk(clk), .rst_n(rst_n), .bus(if8));
  serial_adder #(.WIDTH(8), .DIGIT(2)) u_w82 (.clk(clk), .rst_n(rst_n), .bus(if82));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One operation on the DIGIT=1 instance, entered from IDLE.
  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic ci, input logic sub,
                     input logic [7:0] es, input logic eco, input logic eovf);
    if8.a = a; if8.b = b; if8.ci = ci; if8.sub = sub; if8.start = 1'b1;
    tick();
    if8.start = 1'b0;
    chk({tag, ".busy0"}, 32'(if8.busy), 32'd1);
    chk({tag, ".done0"}, 32'(if8.done), 32'd0);
    for (int k = 1; k < 8; k++) begin
      tick();
      chk({tag, ".early"}, 32'(if8.done), 32'd0);
    end
    tick();
    chk({tag, ".done"}, 32'(if8.done), 32'd1);
    chk({tag, ".busy"}, 32'(if8.busy), 32'd0);
    chk({tag, ".s"},    32'(if8.s),    32'(es));
    chk({tag, ".co"},   32'(if8.co),   32'(eco));
`ifdef SERIAL_ADDER_OVF_EN
    chk({tag, ".ovf"},  32'(if8.ovf),  32'(eovf));
`else
    unused_ovf_exp = eovf;
`endif
    tick();
    chk({tag, ".pulse"}, 32'(if8.done), 32'd0);
    chk({tag, ".hold"},  32'(if8.s),    32'(es));
  endtask

  // One operation on the DIGIT=2 instance, entered from IDLE.
  task automatic op82(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic ci, input logic sub,
                      input logic [7:0] es, input logic eco, input logic eovf);
    if82.a = a; if82.b = b; if82.ci = ci; if82.sub = sub; if82.start = 1'b1;
    tick();
    if82.start = 1'b0;
    chk({tag, ".busy0"}, 32'(if82.busy), 32'd1);
    for (int k = 1; k < 4; k++) begin
      tick();
      chk({tag, ".early"}, 32'(if82.done), 32'd0);
    end
    tick();
    chk({tag, ".done"}, 32'(if82.done), 32'd1);
    chk({tag, ".s"},    32'(if82.s),    32'(es));
    chk({tag, ".co"},   32'(if82.co),   32'(eco));
`ifdef SERIAL_ADDER_OVF_EN
    chk({tag, ".ovf"},  32'(if82.ovf),  32'(eovf));
`else
    unused_ovf_exp = eovf;
`endif
    tick();
    chk({tag, ".pulse"}, 32'(if82.done), 32'd0);
  endtask

  initial begin
    logic [7:0] par_tab;
    logic [7:0] maj_tab;
    logic [2:0] v;
    int         cyc;
    int         ndone;
    int         first;
    logic       got;

    // Reset with random inputs.
    rst_n = 1'b0;
    if1.start = 1'($urandom); if1.sub = 1'($urandom); if1.ci = 1'($urandom);
    if1.a = 1'($urandom); if1.b = 1'($urandom);
    if8.start = 1'($urandom); if8.sub = 1'($urandom); if8.ci = 1'($urandom);
    if8.a = 8'($urandom); if8.b = 8'($urandom);
    if82.start = 1'($urandom); if82.sub = 1'($urandom); if82.ci = 1'($urandom);
    if82.a = 8'($urandom); if82.b = 8'($urandom);
    repeat (3) tick();
    chk("rst.w1.s",    32'(if1.s),     32'd0);
    chk("rst.w1.co",   32'(if1.co),    32'd0);
    chk("rst.w8.s",    32'(if8.s),     32'd0);
    chk("rst.w8.co",   32'(if8.co),    32'd0);
    chk("rst.w8.busy", 32'(if8.busy),  32'd0);
    chk("rst.w8.done", 32'(if8.done),  32'd0);
    chk("rst.w82.s",   32'(if82.s),    32'd0);
    chk("rst.w82.busy",32'(if82.busy), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("rst.w8.ovf",  32'(if8.ovf),   32'd0);
`endif
    if1.start = 1'b0; if8.start = 1'b0; if82.start = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // WIDTH=1 full-adder truth table, index {ci,a,b}.
    par_tab = 8'b1001_0110;
    maj_tab = 8'b1110_1000;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      if1.ci = v[2]; if1.a = v[1]; if1.b = v[0]; if1.sub = 1'b0; if1.start = 1'b1;
      tick();
      if1.start = 1'b0;
      chk($sformatf("w1[%0d].busy", i), 32'(if1.busy), 32'd1);
      chk($sformatf("w1[%0d].early", i), 32'(if1.done), 32'd0);
      tick();
      chk($sformatf("w1[%0d].done", i), 32'(if1.done), 32'd1);
      chk($sformatf("w1[%0d].s", i),    32'(if1.s),    32'(par_tab[i]));
      chk($sformatf("w1[%0d].co", i),   32'(if1.co),   32'(maj_tab[i]));
      tick();
      chk($sformatf("w1[%0d].pulse", i), 32'(if1.done), 32'd0);
    end

    // DIGIT=1 additions.
    op8("ff+01",    8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    op8("3c+5a+1",  8'h3C, 8'h5A, 1'b1, 1'b0, 8'h97, 1'b0, 1'b1);

    // DIGIT=2 subtractions and a wrap-around add.
    op82("05-07",   8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
    op82("80-01-1", 8'h80, 8'h01, 1'b1, 1'b1, 8'h7E, 1'b1, 1'b1);
    op82("a5+5a+1", 8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);

    // start pulsed during RUN must be ignored.
    if8.a = 8'h10; if8.b = 8'h20; if8.ci = 1'b0; if8.sub = 1'b0; if8.start = 1'b1;
    tick();
    if8.start = 1'b0;
    ndone = 0;
    first = -1;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (c == 3) begin if8.a = 8'h01; if8.b = 8'h01; if8.start = 1'b1; end
      if (c == 4) if8.start = 1'b0;
      if (if8.done) begin
        ndone++;
        if (first < 0) first = c;
      end
    end
    chk("ign.ndone", 32'(ndone), 32'd1);
    chk("ign.lat",   32'(first), 32'd8);
    chk("ign.s",     32'(if8.s), 32'h30);

    // start held through DONE: back-to-back second operation.
    if8.a = 8'h11; if8.b = 8'h22; if8.ci = 1'b0; if8.sub = 1'b0; if8.start = 1'b1;
    tick();
    for (int k = 1; k < 8; k++) begin
      tick();
      chk("b2b.early", 32'(if8.done), 32'd0);
      if (k == 4) begin if8.a = 8'hC0; if8.b = 8'h50; end
    end
    tick();
    chk("b2b.done1", 32'(if8.done), 32'd1);
    chk("b2b.s1",    32'(if8.s),    32'h33);
    chk("b2b.co1",   32'(if8.co),   32'd0);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 20) begin
      tick();
      cyc++;
      if (cyc == 1) begin
        chk("b2b.busy", 32'(if8.busy), 32'd1);
        if8.start = 1'b0;
      end
      if (if8.done) got = 1'b1;
    end
    chk("b2b.gap", 32'(cyc),   32'd9);
    chk("b2b.s2",  32'(if8.s), 32'h10);
    chk("b2b.co2", 32'(if8.co),32'd1);
    tick();

    // Reset in the middle of a run: outputs clear at once, no done follows.
    if8.a = 8'hFF; if8.b = 8'hFF; if8.start = 1'b1;
    tick();
    if8.start = 1'b0;
    repeat (3) tick();
    chk("mid.busy_pre", 32'(if8.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid.s",     32'(if8.s),    32'd0);
    chk("mid.co",    32'(if8.co),   32'd0);
    chk("mid.busy",  32'(if8.busy), 32'd0);
    chk("mid.done",  32'(if8.done), 32'd0);
    chk("mid.w82.s", 32'(if82.s),   32'd0);
    chk("mid.w82.co",32'(if82.co),  32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("mid.ovf",   32'(if82.ovf), 32'd0);
`endif
    repeat (2) tick();
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (if8.done) ndone++;
    end
    chk("mid.nodone", 32'(ndone),    32'd0);
    chk("mid.idle",   32'(if8.busy), 32'd0);

    // Signed overflow boundary.
    op8("7f+01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Multi-cycle, parametrised N-bit adder/subtractor. It processes DIGIT bits of the operands per clock, keeps the carry in a register between steps, and uses a start/done handshake. It is the sequential successor to the single-bit full-adder cells and reuses their sum/carry equations inside one digit slice. It is intended for area-constrained datapaths where latency of WIDTH/DIGIT cycles is acceptable.

## Interface
- WIDTH, 8: operand and result width in bits; must be at least 1.
- DIGIT, 1: bits processed per cycle; WIDTH must be an exact multiple of DIGIT. NSTEP = WIDTH/DIGIT.
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only while the block is in IDLE or DONE.
- sub  input  1  0 = add, 1 = subtract; captured with start.
- a  input  WIDTH  operand A; captured with start.
- b  input  WIDTH  operand B; captured with start.
- ci  input  1  carry-in (borrow-in when sub=1); captured with start.
- busy  output  1  high while the FSM is in RUN.
- done  output  1  one-cycle pulse marking s/co valid.
- s  output  WIDTH  result register.
- co  output  1  carry-out (equals NOT borrow when sub=1).
- ovf  output  1  signed overflow; present only with SERIAL_ADDER_OVF_EN.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - start=1 → RUN.
  - Captures opA=a, opB = sub ? ~b : b, carry = ci ^ sub. This computes a+b+ci, or a−b−ci as a+~b+~ci.
  - Clears the step counter to 0.
- **RUN**
  - Each cycle, adds the low DIGIT bits of opA, opB and carry with a ripple of full-adder cells.
  - Shifts opA and opB right by DIGIT; shifts the DIGIT sum bits into the top of a WIDTH-bit accumulator.
  - Registers the slice carry-out into carry; increments the counter.
  - When counter = NSTEP−1: → DONE, and loads s = accumulator (final slice included) and co = carry.
- **DONE**
  - done=1 for exactly this cycle.
  - start=1 → RUN with a fresh capture (back-to-back); otherwise → IDLE.
- start while in RUN is ignored; there is no queueing.
- s, co and ovf change only on the RUN→DONE edge. They hold their value until the next completion.
- Arithmetic is modulo 2^WIDTH; the carry beyond bit WIDTH−1 appears only on co.
- Reset (async, any state): state=IDLE, counter=0, carry=0, accumulator=0, busy=0, done=0, s=0, co=0, ovf=0. An operation interrupted by reset is discarded, and no done is issued for it.

## Timing
- start sampled high at edge E0 → busy=1 from E0 through edge E0+NSTEP.
- done=1 for one cycle, from edge E0+NSTEP to edge E0+NSTEP+1. s and co are valid from edge E0+NSTEP.
- Throughput:
  - back-to-back (start held or reasserted during DONE): one result every NSTEP+1 cycles;
  - via IDLE: NSTEP+2 cycles.
- busy and done are registered outputs; no combinational path runs from inputs to outputs.

## Configuration
- SERIAL_ADDER_OVF_EN defined:
  - the ovf port exists;
  - ovf = carry into bit WIDTH−1 XOR carry out of bit WIDTH−1, both taken in the final step;
  - registered with s; reset 0.
- SERIAL_ADDER_OVF_EN undefined:
  - the port and its logic are absent;
  - all other behaviour is identical.

## Structure
- Shared package serial_adder_pkg holds:
  - the FSM state enum {IDLE, RUN, DONE};
  - the function computing the counter width as clog2(NSTEP), minimum 1.
- One sub-module, digit_adder: a purely combinational DIGIT-bit ripple adder.
  - Inputs: a, b, ci.
  - Outputs: s, co, and c_msb_in (the carry into its MSB, used for ovf).

## Test plan
- Reset: hold rst_n=0 with random inputs → s=0, co=0, busy=0, done=0, ovf=0.
- WIDTH=1, DIGIT=1, sub=0, all 8 {ci,a,b} combinations → s=a^b^ci, co=majority(a,b,ci); done 1 cycle after start.
- WIDTH=8, DIGIT=1: a=8'hFF, b=8'h01, ci=0, sub=0 → done 8 cycles after start; s=8'h00, co=1.
- WIDTH=8, DIGIT=2, sub=1, a=8'h05, b=8'h07, ci=0 → done after 4 cycles; s=8'hFE, co=0.
- Handshake, WIDTH=8, DIGIT=1:
  - start pulsed at step 3 of RUN → ignored; exactly one done;
  - start held through DONE → second op begins; next done 9 cycles after the first.
- rst_n pulsed low at step 3 → all outputs 0 immediately; no done.
- With the macro: a=8'h7F, b=8'h01 → s=8'h80, ovf=1, co=0.
